dmem_arbiter: RTL and testbench

Shares the single data-memory port between two requesters:
- port 0: core load/store path (rs1+imm address, rs2 store data, func3).
- port 1: secondary master (program loader / debug).

Round-robin, one outstanding transaction, registered request capture, registered response return.

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core LSU (port 0) and a secondary master (port 1).
// Optional issue-to-response watchdog enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [2:0]            func3_0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  err0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [2:0]            func3_1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err1,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  logic   sel;
  logic   last_grant;
  logic   pick_c;
  logic   done_c;
  logic   timeout_c;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dmem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  // On a tie the port that did not win last time goes next
  assign pick_c = (req0 && req1) ? ~last_grant : req1;
  assign done_c = (state == RESP) && mem_rvalid;

  // Grant is the memory's acceptance, steered to the owner of the issue registers
  assign gnt0 = (state == ISSUE) && mem_ready && !sel;
  assign gnt1 = (state == ISSUE) && mem_ready && sel;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Acceptance in the last ISSUE cycle still gets one RESP cycle before aborting
  assign timeout_c = (state != IDLE) && !done_c && !((state == ISSUE) && mem_ready)
                     && (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt + CNT_W'(1);
      if (done_c || timeout_c) begin
        if (sel) err1 <= timeout_c;
        else     err0 <= timeout_c;
      end
    end
  end
`else
  assign timeout_c = 1'b0;
  assign err0      = 1'b0;
  assign err1      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_func3  <= '0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel        <= pick_c;
            last_grant <= pick_c;
            mem_req    <= 1'b1;
            mem_we     <= pick_c ? we1     : we0;
            mem_addr   <= pick_c ? addr1   : addr0;
            mem_wdata  <= pick_c ? wdata1  : wdata0;
            mem_func3  <= pick_c ? func3_1 : func3_0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= RESP;
          end
        end
        RESP:    ;
        default: state <= IDLE;
      endcase

      // Completion or abort: pulse the owner's rvalid and return to IDLE
      if (done_c || timeout_c) begin
        mem_req <= 1'b0;
        state   <= IDLE;
        if (sel) begin
          rvalid1 <= 1'b1;
          rdata1  <= done_c ? mem_rdata : '0;
        end else begin
          rvalid0 <= 1'b1;
          rdata0  <= done_c ? mem_rdata : '0;
        end
      end
    end
  end

  a_gnt_exclusive: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
  a_rvalid_exclusive: assert property (@(posedge clk) disable iff (rst) !(rvalid0 && rvalid1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; the bench plays the memory and both requesters.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [2:0]    func3_0, func3_1;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_req, mem_we, mem_ready, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [2:0]    mem_func3;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .func3_0(func3_0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .func3_1(func3_1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_mem_req(input string tag);
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_mem_req"}, 64'(mem_req), 64'd1);
  endtask

  // Play memory for one transaction: accept after ready_wait stall cycles, respond
  // rsp_wait cycles into RESP, then check the response on the expected port.
  task automatic serve(input string tag, input int port, input int ready_wait,
                       input int rsp_wait, input logic exp_we, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [2:0] exp_f3,
                       input logic [31:0] rd, input bit keep);
    wait_mem_req(tag);
    for (int i = 0; i <= ready_wait; i++) begin
      mem_ready = (i == ready_wait);
      #1;
      check({tag, "_we"},    64'(mem_we),    64'(exp_we));
      check({tag, "_addr"},  64'(mem_addr),  64'(exp_addr));
      check({tag, "_wdata"}, 64'(mem_wdata), 64'(exp_wdata));
      check({tag, "_func3"}, 64'(mem_func3), 64'(exp_f3));
      check({tag, "_gnt"},   64'(port != 0 ? gnt1 : gnt0), 64'(i == ready_wait));
      check({tag, "_gnt_other"}, 64'(port != 0 ? gnt0 : gnt1), 64'd0);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    if (!keep) begin
      if (port != 0) req1 = 1'b0;
      else           req0 = 1'b0;
    end
    check({tag, "_req_drop"}, 64'(mem_req), 64'd0);
    for (int i = 0; i < rsp_wait; i++) @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check({tag, "_rvalid"},       64'(port != 0 ? rvalid1 : rvalid0), 64'd1);
    check({tag, "_rvalid_other"}, 64'(port != 0 ? rvalid0 : rvalid1), 64'd0);
    check({tag, "_rdata"},        64'(port != 0 ? rdata1 : rdata0),   64'(rd));
    check({tag, "_err"},          64'(port != 0 ? err1 : err0),       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; func3_0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; func3_1 = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_gnt",     64'({gnt0, gnt1}), 64'd0);
    check("rst_rvalid",  64'({rvalid0, rvalid1}), 64'd0);
    check("rst_rdata0",  64'(rdata0), 64'd0);
    check("rst_err",     64'({err0, err1}), 64'd0);
    check("rst_addr",    64'(mem_addr), 64'd0);
    rst = 1'b0;

    // Single load on port 0, response two cycles after acceptance
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h2004; wdata0 = '0; func3_0 = 3'b010;
    serve("ld0", 0, 0, 1, 1'b0, 32'h2004, 32'h0, 3'b010, 32'h1234_5678, 1'b0);

    // Single store on port 1 with a short accept stall
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h100; wdata1 = 32'hCAFE_BABE; func3_1 = 3'b000;
    serve("st1", 1, 2, 0, 1'b1, 32'h100, 32'hCAFE_BABE, 3'b000, 32'h0BAD_0000, 1'b0);

    // Both ports request continuously: grants alternate starting with port 0
    we0 = 1'b0; addr0 = 32'h40; wdata0 = 32'h11; func3_0 = 3'b010;
    we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'h22; func3_1 = 3'b001;
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 6; t++) begin
      int p;
      p = t % 2;
      serve($sformatf("rr%0d", t), p, 0, 0, p != 0, (p != 0) ? 32'h80 : 32'h40,
            (p != 0) ? 32'h22 : 32'h11, (p != 0) ? 3'b001 : 3'b010, 32'hA0 + 32'(t), 1'b1);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Memory stalls acceptance for 5 cycles
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h5550; wdata0 = 32'h0F0F; func3_0 = 3'b001;
    serve("stall", 0, 5, 0, 1'b1, 32'h5550, 32'h0F0F, 3'b001, 32'h77, 1'b0);

    // Reset while waiting in RESP, then a late memory response
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h600; func3_0 = 3'b010;
    wait_mem_req("rstresp");
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; req0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    check("rstresp_rvalid",  64'({rvalid0, rvalid1}), 64'd0);
    check("rstresp_rdata0",  64'(rdata0), 64'd0);
    check("rstresp_rdata1",  64'(rdata1), 64'd0);
    check("rstresp_mem_req", 64'(mem_req), 64'd0);
    check("rstresp_addr",    64'(mem_addr), 64'd0);
    check("rstresp_err",     64'({err0, err1}), 64'd0);

    // Tie after reset goes to port 0, then port 1 follows
    we0 = 1'b0; addr0 = 32'h40; wdata0 = 32'h11; func3_0 = 3'b010;
    we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'h22; func3_1 = 3'b001;
    req0 = 1'b1; req1 = 1'b1;
    serve("tie0", 0, 0, 0, 1'b0, 32'h40, 32'h11, 3'b010, 32'h5A5A_0001, 1'b0);
    serve("tie1", 1, 0, 0, 1'b1, 32'h80, 32'h22, 3'b001, 32'h5A5A_0002, 1'b0);

`ifdef DMEM_ARB_TIMEOUT_EN
    // Memory never responds: abort 16 cycles after entering ISSUE
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h700; func3_0 = 3'b010;
    wait_mem_req("to");
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("to_early_rvalid%0d", i), 64'(rvalid0), 64'd0);
    end
    @(negedge clk);
    check("to_rvalid0", 64'(rvalid0), 64'd1);
    check("to_err0",    64'(err0), 64'd1);
    check("to_rdata0",  64'(rdata0), 64'd0);
    check("to_mem_req", 64'(mem_req), 64'd0);
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h900; wdata1 = 32'h33; func3_1 = 3'b100;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    check("to_late_rvalid", 64'({rvalid0, rvalid1}), 64'd0);
    serve("to_after", 1, 0, 1, 1'b0, 32'h900, 32'h33, 3'b100, 32'h0000_BEEF, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
